// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU datapath types: the machine word, the ALU opcode encoding, the
// opcode driven onto the ALU bus when nobody owns it, and the record that
// holds one registered ALU response.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    // Opcode presented to the ALU on idle cycles. SLL of 0 by 0 keeps the
    // ALU inputs and outputs static, so the shared bus does not toggle.
    localparam aluop_t ALU_IDLE_OP = ALU_SLL;

    // One registered response slot.
    typedef struct packed {
        word_t res;
        logic  zero;
        logic  neg;
        logic  ovf;
    } alu_rsp_t;

endpackage : cpu_types_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Picks one winner from an eligible mask.
//   RR_EN = 1 : rotating priority, scanning ptr+1, ptr+2, ... ptr (mod NREQ)
//   RR_EN = 0 : fixed priority, lowest index wins (ptr is ignored)
// Ports:
//   elig     in   NREQ  eligible requesters
//   ptr      in   IW    index granted most recently
//   win      out  NREQ  one-hot winner, zero when nothing is eligible
//   win_idx  out  IW    binary index of the winner (0 when none)
//   any      out  1     at least one requester is eligible
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ  = 2,
    parameter bit RR_EN = 1'b1,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx,
    output logic            any
);

    logic [IW-1:0] cand;

    // Both modes walk NREQ candidates in priority order and keep the first
    // eligible one; only the order of the walk differs.
    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (RR_EN) begin
                cand = IW'((int'(ptr) + k) % NREQ);
            end else begin
                cand = IW'(k - 1);
            end
            if (!any && elig[cand]) begin
                any     = 1'b1;
                win_idx = cand;
            end
        end
        if (any) begin
            win[win_idx] = 1'b1;
        end
    end

endmodule : rr_pick

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between NREQ requesters (e.g. EX-stage port and the
// branch/address unit). Each cycle one eligible requester is granted; its
// opcode and operands are steered combinationally to the ALU, and the ALU
// result and flags are registered into that requester's response slot at the
// end of the grant cycle. A slot stays valid until its owner acks it; a full
// slot blocks further grants to that requester only.
// Parameters:
//   NREQ   number of requesters (2..8)
//   RR_EN  1 = round-robin, 0 = fixed priority (lowest index wins)
// Ports:
//   CLK, RST                     clock, asynchronous active-high reset
//   req / op / a / b             per-requester request, opcode, operands
//   gnt                          one-hot-or-zero grant, same cycle as req
//   rsp_valid / rsp_ack          per-slot response handshake
//   rsp_out                      per-slot registered ALU result
//   rsp_zero / rsp_neg / rsp_ovf per-slot registered ALU flags
//   alu_op / alu_a / alu_b       steered ALU inputs (quiet when idle)
//   alu_out / alu_zero / alu_neg / alu_ovf   ALU result and flags
// -----------------------------------------------------------------------------
module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter bit RR_EN = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,

    input  logic  [NREQ-1:0]    req,
    input  aluop_t [NREQ-1:0]   op,
    input  word_t [NREQ-1:0]    a,
    input  word_t [NREQ-1:0]    b,
    output logic  [NREQ-1:0]    gnt,

    output logic  [NREQ-1:0]    rsp_valid,
    input  logic  [NREQ-1:0]    rsp_ack,
    output word_t [NREQ-1:0]    rsp_out,
    output logic  [NREQ-1:0]    rsp_zero,
    output logic  [NREQ-1:0]    rsp_neg,
    output logic  [NREQ-1:0]    rsp_ovf,

    output aluop_t              alu_op,
    output word_t               alu_a,
    output word_t               alu_b,
    input  word_t               alu_out,
    input  logic                alu_zero,
    input  logic                alu_neg,
    input  logic                alu_ovf
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // The ALU drives its overflow flag for every opcode, but it only has a
    // meaning for add/subtract; anything else is recorded as no overflow.
    function automatic logic mask_ovf(input aluop_t o, input logic ovf);
        return ((o == ALU_ADD) || (o == ALU_SUB)) ? ovf : 1'b0;
    endfunction

    logic [IW-1:0]   last_gnt;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] win;
    logic [IW-1:0]   win_idx;
    logic            win_any;
    logic            grant_any;
    alu_rsp_t        alu_rsp_p0;

    // ---- Stage p0: eligibility, selection, steering (combinational) ----

    // Acking in the same cycle frees the slot in time for a new grant, which
    // is what allows one op per cycle per requester.
    assign elig = req & (~rsp_valid | rsp_ack);

    rr_pick #(
        .NREQ  (NREQ),
        .RR_EN (RR_EN)
    ) u_pick (
        .elig    (elig),
        .ptr     (last_gnt),
        .win     (win),
        .win_idx (win_idx),
        .any     (win_any)
    );

    // Reset suppresses the grant outright so nothing can be captured or
    // handed out while the block is held in reset.
    assign grant_any = win_any & ~RST;
    assign gnt       = grant_any ? win : '0;

    always_comb begin
        alu_op = ALU_IDLE_OP;
        alu_a  = '0;
        alu_b  = '0;
        if (grant_any) begin
            alu_op = op[win_idx];
            alu_a  = a[win_idx];
            alu_b  = b[win_idx];
        end
    end

    always_comb begin
        alu_rsp_p0.res  = alu_out;
        alu_rsp_p0.zero = alu_zero;
        alu_rsp_p0.neg  = alu_neg;
        alu_rsp_p0.ovf  = mask_ovf(alu_op, alu_ovf);
    end

    // ---- Stage p1: arbitration pointer and response slots (registered) ----

    // The pointer only moves on a real grant, so idle cycles do not disturb
    // the rotation order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_gnt <= IW'(NREQ - 1);
        end else if (grant_any) begin
            last_gnt <= win_idx;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        logic     vld_p1;
        alu_rsp_t rsp_p1;

        // A grant wins over an ack in the same cycle: the fresh result
        // replaces the consumed one and the slot stays valid.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                vld_p1 <= 1'b0;
                rsp_p1 <= '0;
            end else if (gnt[g]) begin
                vld_p1 <= 1'b1;
                rsp_p1 <= alu_rsp_p0;
            end else if (rsp_ack[g]) begin
                vld_p1 <= 1'b0;
            end
        end

        assign rsp_valid[g] = vld_p1;
        assign rsp_out[g]   = rsp_p1.res;
        assign rsp_zero[g]  = rsp_p1.zero;
        assign rsp_neg[g]   = rsp_p1.neg;
        assign rsp_ovf[g]   = rsp_p1.ovf;
    end

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Drives one round-robin and one fixed-priority alu_arbiter from the same
// requester inputs, each backed by a behavioural ALU, and compares both
// against a slot/pointer reference model every cycle.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    import cpu_types_pkg::*;

    localparam int N = 3;

    typedef struct packed {
        word_t res;
        logic  z;
        logic  n;
        logic  v;
    } ares_t;

    logic             CLK;
    logic             RST;
    logic   [N-1:0]   req;
    aluop_t [N-1:0]   op;
    word_t  [N-1:0]   a;
    word_t  [N-1:0]   b;
    logic   [N-1:0]   rsp_ack;

    // index 0 = round-robin DUT, index 1 = fixed-priority DUT
    logic   [N-1:0]   gnt_o       [2];
    logic   [N-1:0]   rsp_valid_o [2];
    word_t  [N-1:0]   rsp_out_o   [2];
    logic   [N-1:0]   rsp_zero_o  [2];
    logic   [N-1:0]   rsp_neg_o   [2];
    logic   [N-1:0]   rsp_ovf_o   [2];
    aluop_t           alu_op_o    [2];
    word_t            alu_a_o     [2];
    word_t            alu_b_o     [2];
    ares_t            alu_res     [2];

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    logic  [N-1:0] m_vld [2];
    word_t         m_out [2][N];
    logic          m_z   [2][N];
    logic          m_n   [2][N];
    logic          m_v   [2][N];
    int            m_last[2];
    int            w_last[2];
    logic  [N-1:0] obs_gnt[2];
    int            wait_cnt[N];

    // Behavioural ALU. Overflow is junk for non add/sub opcodes on purpose.
    function automatic ares_t alu_f(aluop_t o, word_t x, word_t y);
        ares_t r;
        r = '0;
        case (o)
            ALU_ADD:  begin r.res = x + y; r.v = (x[31] == y[31]) && (r.res[31] != x[31]); end
            ALU_SUB:  begin r.res = x - y; r.v = (x[31] != y[31]) && (r.res[31] != x[31]); end
            ALU_AND:  r.res = x & y;
            ALU_OR:   r.res = x | y;
            ALU_XOR:  r.res = x ^ y;
            ALU_SLL:  r.res = x << y[4:0];
            ALU_SRL:  r.res = x >> y[4:0];
            ALU_SRA:  r.res = word_t'($signed(x) >>> y[4:0]);
            ALU_SLT:  r.res = {31'b0, ($signed(x) < $signed(y))};
            ALU_SLTU: r.res = {31'b0, (x < y)};
            default:  r.res = '0;
        endcase
        if (o != ALU_ADD && o != ALU_SUB) r.v = x[0] ^ y[1];
        r.z = (r.res == 32'd0);
        r.n = r.res[31];
        return r;
    endfunction

    assign alu_res[0] = alu_f(alu_op_o[0], alu_a_o[0], alu_b_o[0]);
    assign alu_res[1] = alu_f(alu_op_o[1], alu_a_o[1], alu_b_o[1]);

    alu_arbiter #(.NREQ(N), .RR_EN(1'b1)) u_rr (
        .CLK(CLK), .RST(RST), .req(req), .op(op), .a(a), .b(b), .gnt(gnt_o[0]),
        .rsp_valid(rsp_valid_o[0]), .rsp_ack(rsp_ack), .rsp_out(rsp_out_o[0]),
        .rsp_zero(rsp_zero_o[0]), .rsp_neg(rsp_neg_o[0]), .rsp_ovf(rsp_ovf_o[0]),
        .alu_op(alu_op_o[0]), .alu_a(alu_a_o[0]), .alu_b(alu_b_o[0]),
        .alu_out(alu_res[0].res), .alu_zero(alu_res[0].z), .alu_neg(alu_res[0].n),
        .alu_ovf(alu_res[0].v)
    );

    alu_arbiter #(.NREQ(N), .RR_EN(1'b0)) u_fp (
        .CLK(CLK), .RST(RST), .req(req), .op(op), .a(a), .b(b), .gnt(gnt_o[1]),
        .rsp_valid(rsp_valid_o[1]), .rsp_ack(rsp_ack), .rsp_out(rsp_out_o[1]),
        .rsp_zero(rsp_zero_o[1]), .rsp_neg(rsp_neg_o[1]), .rsp_ovf(rsp_ovf_o[1]),
        .alu_op(alu_op_o[1]), .alu_a(alu_a_o[1]), .alu_b(alu_b_o[1]),
        .alu_out(alu_res[1].res), .alu_zero(alu_res[1].z), .alu_neg(alu_res[1].n),
        .alu_ovf(alu_res[1].v)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner by the arbitration rules: d=0 rotates after the last grant,
    // d=1 takes the lowest eligible index. -1 means no grant.
    function automatic int pick(int d, logic [N-1:0] el);
        int j;
        if (d == 0) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_last[0] + k) % N;
                if (el[j]) return j;
            end
        end else begin
            for (int i = 0; i < N; i++) if (el[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_vld[d]  = '0;
            m_last[d] = N - 1;
            w_last[d] = -1;
            for (int i = 0; i < N; i++) begin
                m_out[d][i] = '0; m_z[d][i] = 1'b0; m_n[d][i] = 1'b0; m_v[d][i] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    endtask

    task automatic set_idle();
        req = '0;
        rsp_ack = '0;
        for (int i = 0; i < N; i++) begin
            op[i] = ALU_ADD; a[i] = '0; b[i] = '0;
        end
    endtask

    task automatic check_slots();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("d%0d valid%0d", d, i), rsp_valid_o[d][i], m_vld[d][i]);
                chk($sformatf("d%0d out%0d", d, i), rsp_out_o[d][i], m_out[d][i]);
                chk($sformatf("d%0d zero%0d", d, i), rsp_zero_o[d][i], m_z[d][i]);
                chk($sformatf("d%0d neg%0d", d, i), rsp_neg_o[d][i], m_n[d][i]);
                chk($sformatf("d%0d ovf%0d", d, i), rsp_ovf_o[d][i], m_v[d][i]);
            end
        end
    endtask

    // Called 1 time unit after a rising edge with inputs already applied.
    task automatic do_cycle();
        logic [N-1:0] el;
        logic [N-1:0] eg;
        int           w;
        ares_t        r;
        #2;
        for (int d = 0; d < 2; d++) begin
            el = req & (~m_vld[d] | rsp_ack);
            w  = pick(d, el);
            w_last[d]  = w;
            eg = (w < 0) ? '0 : (N'(1) << w);
            obs_gnt[d] = gnt_o[d];
            chk($sformatf("d%0d gnt", d), gnt_o[d], eg);
            chk($sformatf("d%0d alu_op", d), alu_op_o[d], (w < 0) ? ALU_SLL : op[w]);
            chk($sformatf("d%0d alu_a", d), alu_a_o[d], (w < 0) ? 32'd0 : a[w]);
            chk($sformatf("d%0d alu_b", d), alu_b_o[d], (w < 0) ? 32'd0 : b[w]);
            if (d == 0) begin
                for (int i = 0; i < N; i++) begin
                    if (el[i] && w != i) wait_cnt[i]++;
                    else wait_cnt[i] = 0;
                    if (el[i]) chk($sformatf("rr fair%0d", i), (wait_cnt[i] <= N - 1), 1);
                end
            end
        end
        @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                if (i == w_last[d]) begin
                    r = alu_f(op[i], a[i], b[i]);
                    m_vld[d][i] = 1'b1;
                    m_out[d][i] = r.res;
                    m_z[d][i]   = r.z;
                    m_n[d][i]   = r.n;
                    m_v[d][i]   = (op[i] == ALU_ADD || op[i] == ALU_SUB) ? r.v : 1'b0;
                end else if (rsp_ack[i]) begin
                    m_vld[d][i] = 1'b0;
                end
            end
            if (w_last[d] >= 0) m_last[d] = w_last[d];
        end
        check_slots();
    endtask

    function automatic word_t rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [N-1:0] rr_exp [4];
        rr_exp[0] = 3'b010; rr_exp[1] = 3'b001; rr_exp[2] = 3'b010; rr_exp[3] = 3'b001;

        // reset state: grant forced low even with requests pending
        RST = 1'b1;
        set_idle();
        req = 3'b111;
        model_reset();
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst d%0d gnt", d), gnt_o[d], 3'b000);
            chk($sformatf("rst d%0d valid", d), rsp_valid_o[d], 3'b000);
            chk($sformatf("rst d%0d alu_op", d), alu_op_o[d], ALU_SLL);
        end
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
        set_idle();

        // single ADD 5+7 on requester 0
        req = 3'b001; op[0] = ALU_ADD; a[0] = 32'd5; b[0] = 32'd7;
        do_cycle();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t2 d%0d gnt", d), obs_gnt[d], 3'b001);
            chk($sformatf("t2 d%0d out0", d), rsp_out_o[d][0], 32'd12);
            chk($sformatf("t2 d%0d valid0", d), rsp_valid_o[d][0], 1'b1);
            chk($sformatf("t2 d%0d zero0", d), rsp_zero_o[d][0], 1'b0);
        end
        req = '0; rsp_ack = 3'b001;
        do_cycle();

        // two requesters held, acking every cycle
        req = 3'b011; rsp_ack = 3'b011;
        op[0] = ALU_ADD; a[0] = 32'd10; b[0] = 32'd20;
        op[1] = ALU_XOR; a[1] = 32'hF0F0_0000; b[1] = 32'h0FF0_0000;
        for (int c = 0; c < 4; c++) begin
            do_cycle();
            chk($sformatf("t3 rr gnt c%0d", c), obs_gnt[0], rr_exp[c]);
            chk($sformatf("t3 fp gnt c%0d", c), obs_gnt[1], 3'b001);
        end
        req = '0; rsp_ack = 3'b111;
        do_cycle();

        // SUB overflow, then slot 1 held without ack
        req = 3'b010; rsp_ack = '0;
        op[1] = ALU_SUB; a[1] = 32'h8000_0000; b[1] = 32'd1;
        do_cycle();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t4 d%0d out1", d), rsp_out_o[d][1], 32'h7FFF_FFFF);
            chk($sformatf("t4 d%0d ovf1", d), rsp_ovf_o[d][1], 1'b1);
        end
        req = 3'b011; rsp_ack = 3'b001;
        op[0] = ALU_ADD; a[0] = 32'd9; b[0] = 32'd9;
        op[1] = ALU_OR;  a[1] = 32'd3; b[1] = 32'd4;
        for (int c = 0; c < 3; c++) begin
            do_cycle();
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("t4 d%0d blk gnt c%0d", d, c), obs_gnt[d], 3'b001);
                chk($sformatf("t4 d%0d held1 c%0d", d, c), rsp_out_o[d][1], 32'h7FFF_FFFF);
            end
        end
        req = '0; rsp_ack = 3'b111;
        do_cycle();

        // same-cycle grant and ack on slot 0
        req = 3'b001; rsp_ack = '0; op[0] = ALU_ADD; a[0] = 32'd1; b[0] = 32'd1;
        do_cycle();
        for (int d = 0; d < 2; d++) chk($sformatf("t5 d%0d out0 a", d), rsp_out_o[d][0], 32'd2);
        rsp_ack = 3'b001; a[0] = 32'd2; b[0] = 32'd2;
        do_cycle();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t5 d%0d valid0", d), rsp_valid_o[d][0], 1'b1);
            chk($sformatf("t5 d%0d out0 b", d), rsp_out_o[d][0], 32'd4);
        end

        // idle bus, then an ack against an empty slot
        req = '0; rsp_ack = 3'b001;
        do_cycle();
        do_cycle();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t6 d%0d alu_a", d), alu_a_o[d], 32'd0);
            chk($sformatf("t6 d%0d out0 kept", d), rsp_out_o[d][0], 32'd4);
        end

        // asynchronous reset in the middle of a cycle with full slots
        req = 3'b011; rsp_ack = '0;
        do_cycle();
        RST = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t1 d%0d valid", d), rsp_valid_o[d], 3'b000);
            chk($sformatf("t1 d%0d gnt", d), gnt_o[d], 3'b000);
            for (int i = 0; i < N; i++)
                chk($sformatf("t1 d%0d out%0d", d, i), rsp_out_o[d][i], 32'd0);
        end
        #3;
        RST = 1'b0;
        model_reset();
        set_idle();
        @(posedge CLK); #1;

        // randomized traffic; an ungranted request keeps its op and operands
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req[i] && !(w_last[0] == i && w_last[1] == i))) begin
                    req[i] = ($urandom_range(0, 3) != 0);
                    op[i]  = aluop_t'($urandom_range(0, 9));
                    a[i]   = rnd_word();
                    b[i]   = rnd_word();
                end
                rsp_ack[i] = ($urandom_range(0, 2) != 0);
            end
            do_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_alu_arbiter
